clk_div_ctrl: RTL and testbench

- Run-controlled, reprogrammable clock-enable scheduler for the system clock domain.
- Counts `sys_clk` cycles and emits a one-cycle `clk_en` pulse every `cur_div` cycles, plus an optional registered divided clock.
- Accepts new divide ratios over a valid/ready handshake and applies them only at period boundaries, so no runt periods ever occur.
- Downstream logic advances on `clk_en` instead of on a derived clock.

---
 rtl/clk_div_ctrl.sv | 119 +++++++++++
 tb/tb_clk_div_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// Run-controlled clock-enable scheduler: pulses clk_en every cur_div sys_clk cycles.
// Define CLK_DIV_OUT_EN to add the registered divided-clock output clk_div.
module clk_div_ctrl #(
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned DIV_INIT = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clk_en,
  output logic             active,
  output logic [DIV_W-1:0] cur_div
`ifdef CLK_DIV_OUT_EN
  ,
  output logic             clk_div
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_vld_d;
  logic             accept;
  logic             boundary;
  logic [DIV_W-1:0] cfg_div_cl;
  logic             clk_en_d;
  logic             active_d;
  logic             clk_div_d;

  // Next-state and next-output logic; outputs are precomputed so they leave flops
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_d      = cur_div;
    pend_div_d = pend_div_q;
    pend_vld_d = !cfg_ready;
    accept     = cfg_valid && cfg_ready;
    cfg_div_cl = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
    boundary   = (state_q != S_IDLE) && (cnt_q == cur_div - DIV_W'(1));

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // A ratio left pending by a stop that ended on its acceptance edge
        if (!cfg_ready) begin
          cur_d      = pend_div_q;
          pend_vld_d = 1'b0;
        end
        if (accept) cur_d = cfg_div_cl;
        if (run) state_d = S_RUN;
      end
      S_RUN, S_STOP: begin
        cnt_d = boundary ? '0 : cnt_q + DIV_W'(1);
        if (boundary && !cfg_ready) begin
          cur_d      = pend_div_q;
          pend_vld_d = 1'b0;
        end
        if (accept) begin
          pend_div_d = cfg_div_cl;
          pend_vld_d = 1'b1;
        end
        if (state_q == S_RUN) begin
          if (!run) state_d = S_STOP;
        end else if (run) begin
          state_d = S_RUN;
        end else if (boundary) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    active_d  = (state_d != S_IDLE);
    clk_en_d  = active_d && (cnt_d == cur_d - DIV_W'(1));
    clk_div_d = active_d && (cnt_d >= (cur_d >> 1));
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cur_div    <= DIV_W'(DIV_INIT);
      pend_div_q <= '0;
      cfg_ready  <= 1'b1;
      clk_en     <= 1'b0;
      active     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_div    <= cur_d;
      pend_div_q <= pend_div_d;
      cfg_ready  <= !pend_vld_d;
      clk_en     <= clk_en_d;
      active     <= active_d;
    end
  end

`ifdef CLK_DIV_OUT_EN
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) clk_div <= 1'b0;
    else         clk_div <= clk_div_d;
  end
`else
  logic unused_clk_div;
  assign unused_clk_div = clk_div_d;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus random traffic vs a period model.
module tb_clk_div_ctrl;

  localparam int unsigned DIV_W    = 8;
  localparam int unsigned DIV_INIT = 2;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             run = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             cfg_ready;
  logic             clk_en;
  logic             active;
  logic [DIV_W-1:0] cur_div;
`ifdef CLK_DIV_OUT_EN
  logic             clk_div;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: whether a period is in progress, position within it, stop request, pending ratio
  bit m_on, m_stop, m_pv;
  int m_pos, m_div, m_pend;

  clk_div_ctrl #(.DIV_W(DIV_W), .DIV_INIT(DIV_INIT)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .run      (run),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .clk_en   (clk_en),
    .active   (active),
    .cur_div  (cur_div)
`ifdef CLK_DIV_OUT_EN
    ,
    .clk_div  (clk_div)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_stop = 0; m_pv = 0; m_pos = 0; m_div = DIV_INIT; m_pend = 0;
  endtask

  task automatic check_all();
    chk("clk_en", 32'(clk_en), 32'(m_on && (m_pos == m_div - 1)));
    chk("active", 32'(active), 32'(m_on));
    chk("cfg_ready", 32'(cfg_ready), 32'(!m_pv));
    chk("cur_div", 32'(cur_div), 32'(m_div));
`ifdef CLK_DIV_OUT_EN
    chk("clk_div", 32'(clk_div), 32'(m_on && (m_pos >= m_div / 2)));
`endif
  endtask

  // Advance the model by one edge using the inputs as sampled at that edge
  task automatic model_edge();
    bit acc, bnd;
    int cl;
    acc = cfg_valid && !m_pv;
    cl  = (cfg_div == 0) ? 1 : int'(cfg_div);
    if (!m_on) begin
      if (m_pv) begin m_div = m_pend; m_pv = 0; end
      if (acc) m_div = cl;
      m_pos = 0;
      if (run) begin m_on = 1; m_stop = 0; end
    end else begin
      bnd = (m_pos == m_div - 1);
      m_pos = bnd ? 0 : m_pos + 1;
      if (bnd && m_pv) begin m_div = m_pend; m_pv = 0; end
      if (acc) begin m_pend = cl; m_pv = 1; end
      if (m_stop) begin
        if (run) m_stop = 0;
        else if (bnd) begin m_on = 0; m_pos = 0; end
      end else if (!run) begin
        m_stop = 1;
      end
    end
  endtask

  // One clock: drive inputs, take the edge, then check all outputs #1 later
  task automatic step(input bit r, input bit v, input int d);
    run = r; cfg_valid = v; cfg_div = DIV_W'(d);
    model_edge();
    @(posedge sys_clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    #2;
    model_reset();
    check_all();
    @(posedge sys_clk);
    #1;
    check_all();
    sys_rst = 1'b0;
    run = 0; cfg_valid = 0; cfg_div = '0;
  endtask

  initial begin
    model_reset();
    @(posedge sys_clk);
    #1;
    do_reset();
    chk("rst_cur_div", 32'(cur_div), 32'(DIV_INIT));
    chk("rst_ready", 32'(cfg_ready), 32'd1);

    // Default ratio 2: first pulse two cycles after run is sampled
    step(1, 0, 0);
    chk("div2_first_low", 32'(clk_en), 32'd0);
    step(1, 0, 0);
    chk("div2_first_pulse", 32'(clk_en), 32'd1);
    for (int i = 0; i < 6; i++) step(1, 0, 0);

    // Stop, load ratio 4 in IDLE, then mid-period change to 3 at cnt=1
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    chk("idle_active", 32'(active), 32'd0);
    step(0, 1, 4);
    chk("idle_load", 32'(cur_div), 32'd4);
    step(1, 0, 0);
    step(1, 1, 3);
    chk("pend_ready_low", 32'(cfg_ready), 32'd0);
    chk("old_ratio_held", 32'(cur_div), 32'd4);
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    chk("switched_to_3", 32'(cur_div), 32'd3);
    chk("ready_back", 32'(cfg_ready), 32'd1);

    // Offer 6 in a boundary cycle: applies one boundary later
    while (!clk_en) step(1, 0, 0);
    step(1, 1, 6);
    for (int i = 0; i < 14; i++) step(1, 0, 0);
    chk("switched_to_6", 32'(cur_div), 32'd6);

    // Stop and resume with ratio 5
    for (int i = 0; i < 8; i++) step(0, 0, 0);
    step(0, 1, 5);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    chk("stopped_idle", 32'(active), 32'd0);
    step(1, 0, 0);
    for (int i = 0; i < 2; i++) step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 0, 0);
    chk("resumed_active", 32'(active), 32'd1);

    // Clamp: ratio 0 accepted in IDLE becomes 1
    for (int i = 0; i < 8; i++) step(0, 0, 0);
    step(0, 1, 0);
    chk("clamp", 32'(cur_div), 32'd1);
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    chk("div1_pulse", 32'(clk_en), 32'd1);

    // Reset while a ratio is pending
    step(1, 0, 0);
    step(1, 1, 7);
    chk("pend_before_rst", 32'(cfg_ready), 32'd0);
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    chk("pend_discarded", 32'(cur_div), 32'(DIV_INIT));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) != 0 ? run : ~run,
             $urandom_range(0, 5) == 0,
             int'($urandom_range(0, 7)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
